uart_8n1: RTL and testbench



---
 rtl/uart8_pkg.sv | 20 ++
 rtl/uart8_baud_gen.sv | 27 ++
 rtl/uart_8n1.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_8n1.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_pkg.sv
// Shared state type, oversampling sample points and baud divisor helper for uart_8n1.
package uart8_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} uartState_t;
    typedef uartState_t rxState_t;
    typedef uartState_t txState_t;

    localparam int SAMPLE_EARLY  = 7;
    localparam int SAMPLE_MID    = 8;
    localparam int SAMPLE_LATE   = 9;
    localparam int TICKS_PER_BIT = 16;

    // Integer clock divisor for one tick, never below one clock.
    function automatic int baudDivisor(input int clockRate, input int baudRate, input int oversample);
        int d;
        d = clockRate / (baudRate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart8_baud_gen.sv
// Clock divider producing a one-cycle tick every DIVISOR clocks; restart re-phases it to zero.
module uart8_baud_gen #(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic rstN,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstN || restart) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CNT_W'(DIVISOR - 1));

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART: 16x oversampled receiver with framing-error flag, plus transmitter.
// Define UART8_MAJORITY_VOTE_EN to decide each rx bit by 2-of-3 vote over ticks 7, 8 and 9.
module uart_8n1
    import uart8_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       rxEn,
    input  logic       rx,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] out,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txBusy,
    output logic       txDone,
    output logic       tx
);

    localparam int RX_DIV = baudDivisor(CLOCK_RATE, BAUD_RATE, TICKS_PER_BIT);
    localparam int TX_DIV = baudDivisor(CLOCK_RATE, BAUD_RATE, 1);
    localparam int TICK_W = $clog2(TICKS_PER_BIT);

    logic              rxMeta_p0, rxSync_p1, rxPrev_p2;
    logic              rxFall;
    rxState_t          rxState, rxStateNext;
    logic              rxTick, rxRestart, rxShiftEn, rxGood, rxBad;
    logic              rxDecide, rxBit;
    logic [TICK_W-1:0] rxTickCnt;
    logic [2:0]        rxBitIdx;
    logic [7:0]        rxShreg;

    // ---- stage p0/p1: synchronizer, p2: edge-detect history ----
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rxMeta_p0 <= 1'b1;
            rxSync_p1 <= 1'b1;
            rxPrev_p2 <= 1'b1;
        end else begin
            rxMeta_p0 <= rx;
            rxSync_p1 <= rxMeta_p0;
            rxPrev_p2 <= rxSync_p1;
        end
    end

    assign rxFall = rxPrev_p2 & ~rxSync_p1;

    uart8_baud_gen #(.DIVISOR(RX_DIV)) rxBaud (
        .clk    (clk),
        .rstN   (rstN),
        .restart(rxRestart),
        .tick   (rxTick)
    );

    always_ff @(posedge clk) begin
        if (!rstN || rxRestart) begin
            rxTickCnt <= '0;
        end else if (rxTick) begin
            rxTickCnt <= rxTickCnt + 1'b1;
        end
    end

`ifdef UART8_MAJORITY_VOTE_EN
    logic rxVote7, rxVote8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk) begin
        if (rxTick && rxTickCnt == TICK_W'(SAMPLE_EARLY - 1)) rxVote7 <= rxSync_p1;
        if (rxTick && rxTickCnt == TICK_W'(SAMPLE_MID - 1))   rxVote8 <= rxSync_p1;
    end

    assign rxDecide = rxTick && (rxTickCnt == TICK_W'(SAMPLE_LATE - 1));
    assign rxBit    = majority3(rxVote7, rxVote8, rxSync_p1);
`else
    assign rxDecide = rxTick && (rxTickCnt == TICK_W'(SAMPLE_MID - 1));
    assign rxBit    = rxSync_p1;
`endif

    always_ff @(posedge clk) begin
        if (!rstN) rxState <= IDLE;
        else       rxState <= rxStateNext;
    end

    always_comb begin
        rxStateNext = rxState;
        rxRestart   = 1'b0;
        rxShiftEn   = 1'b0;
        rxGood      = 1'b0;
        rxBad       = 1'b0;
        case (rxState)
            IDLE:  if (rxFall) begin
                       rxStateNext = START;
                       rxRestart   = 1'b1;
                   end
            START: if (rxDecide) rxStateNext = rxBit ? IDLE : DATA;
            DATA:  if (rxDecide) begin
                       rxShiftEn = 1'b1;
                       if (rxBitIdx == 3'd7) rxStateNext = STOP;
                   end
            STOP:  if (rxDecide) begin
                       if (rxBit) begin
                           rxStateNext = IDLE;
                           rxGood      = 1'b1;
                       end else begin
                           rxStateNext = WAIT;
                           rxBad       = 1'b1;
                       end
                   end
            WAIT:  if (rxSync_p1) rxStateNext = IDLE;
            default: rxStateNext = IDLE;
        endcase
        // Disabling the receiver aborts any frame without Done or Err.
        if (!rxEn) begin
            rxStateNext = IDLE;
            rxRestart   = 1'b0;
            rxShiftEn   = 1'b0;
            rxGood      = 1'b0;
            rxBad       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rxRestart) begin
            rxBitIdx <= 3'd0;
        end else if (rxShiftEn) begin
            rxBitIdx <= rxBitIdx + 3'd1;
            rxShreg  <= {rxBit, rxShreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rxDone <= 1'b0;
            rxErr  <= 1'b0;
            out    <= 8'h00;
        end else begin
            rxDone <= rxGood;
            if (rxGood) out <= rxShreg;
            if (!rxEn || rxRestart) rxErr <= 1'b0;
            else if (rxBad)         rxErr <= 1'b1;
        end
    end

    assign rxBusy = (rxState == START) || (rxState == DATA) || (rxState == STOP);

    txState_t   txState, txStateNext;
    logic       txTick, txLoad, txShift, txFinish;
    logic [2:0] txBitIdx;
    logic [7:0] txShreg;

    uart8_baud_gen #(.DIVISOR(TX_DIV)) txBaud (
        .clk    (clk),
        .rstN   (rstN),
        .restart(txLoad),
        .tick   (txTick)
    );

    always_ff @(posedge clk) begin
        if (!rstN) txState <= IDLE;
        else       txState <= txStateNext;
    end

    always_comb begin
        txStateNext = txState;
        txLoad      = 1'b0;
        txShift     = 1'b0;
        txFinish    = 1'b0;
        case (txState)
            IDLE:  if (txStart) begin
                       txStateNext = START;
                       txLoad      = 1'b1;
                   end
            START: if (txTick) txStateNext = DATA;
            DATA:  if (txTick) begin
                       txShift = 1'b1;
                       if (txBitIdx == 3'd7) txStateNext = STOP;
                   end
            STOP:  if (txTick) begin
                       txStateNext = IDLE;
                       txFinish    = 1'b1;
                   end
            default: txStateNext = IDLE;
        endcase
        if (!txEn) begin
            txStateNext = IDLE;
            txLoad      = 1'b0;
            txShift     = 1'b0;
            txFinish    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (txLoad) begin
            txShreg  <= in;
            txBitIdx <= 3'd0;
        end else if (txShift) begin
            txShreg  <= {1'b0, txShreg[7:1]};
            txBitIdx <= txBitIdx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) txDone <= 1'b0;
        else       txDone <= txFinish;
    end

    always_comb begin
        tx = 1'b1;
        case (txState)
            START:   tx = 1'b0;
            DATA:    tx = txShreg[0];
            default: tx = 1'b1;
        endcase
    end

    assign txBusy = (txState != IDLE);

endmodule

// File: tb/tb_uart_8n1.sv
// Scoreboard bench for uart_8n1 at 12 MHz / 9600 baud (1250 clocks per bit).
`timescale 1ns/1ps
module tb_uart_8n1;

    localparam int BIT_CLKS = 1250;

    logic       clk = 1'b0;
    logic       rstN, rxEn, rxDrive, loop, rxPin;
    logic       rxBusy, rxDone, rxErr;
    logic [7:0] outByte;
    logic       txEn, txStart;
    logic [7:0] inByte;
    logic       txBusy, txDone, tx;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] rxExp[$];
    logic       txExp[$];

    always #5 clk = ~clk;

    assign rxPin = loop ? tx : rxDrive;

    uart_8n1 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600)) dut (
        .clk    (clk),
        .rstN   (rstN),
        .rxEn   (rxEn),
        .rx     (rxPin),
        .rxBusy (rxBusy),
        .rxDone (rxDone),
        .rxErr  (rxErr),
        .out    (outByte),
        .txEn   (txEn),
        .txStart(txStart),
        .in     (inByte),
        .txBusy (txBusy),
        .txDone (txDone),
        .tx     (tx)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushTxFrame(input logic [7:0] d);
        txExp.push_back(1'b0);
        for (int i = 0; i < 8; i++) txExp.push_back(d[i]);
        txExp.push_back(1'b1);
    endtask

    task automatic driveBit(input logic v, input int clks);
        rxDrive = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic sendRx(input logic [7:0] d, input bit badStop);
        driveBit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            driveBit(d[i], BIT_CLKS);
            if (i == 3) check("rxBusyMidFrame", {7'd0, rxBusy}, 8'd1);
        end
        if (badStop) begin
            // Low window 44..79 us into the stop bit covers ticks 7-9.
            driveBit(1'b1, 528);
            driveBit(1'b0, 420);
            driveBit(1'b1, BIT_CLKS - 948);
        end else begin
            driveBit(1'b1, BIT_CLKS);
        end
    endtask

    task automatic startTx(input logic [7:0] d);
        inByte  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    // Receive-side monitor: every rxDone pops one expected byte.
    initial begin : rxMon
        @(posedge rstN);
        forever begin
            @(negedge clk);
            if (rxDone === 1'b1) begin
                if (rxExp.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rxUnexpectedDone: got out=%0h, expected no rxDone", outByte);
                end else begin
                    check("rxOut", outByte, rxExp.pop_front());
                    check("rxErrOnDone", {7'd0, rxErr}, 8'd0);
                end
                @(negedge clk);
                check("rxDonePulseWidth", {7'd0, rxDone}, 8'd0);
            end
        end
    end

    // Transmit-side monitor: decodes tx at bit centres against queued bits.
    initial begin : txMon
        bit got;
        @(posedge rstN);
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                for (int b = 0; b < 10; b++) begin
                    repeat ((b == 0) ? (BIT_CLKS / 2 - 1) : BIT_CLKS) @(negedge clk);
                    if (txExp.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL txUnexpectedBit: got %0b, expected idle line", tx);
                    end else begin
                        check("txBit", {7'd0, tx}, {7'd0, txExp.pop_front()});
                    end
                end
                got = 1'b0;
                for (int w = 0; w < 800 && !got; w++) begin
                    @(negedge clk);
                    if (txDone === 1'b1) got = 1'b1;
                end
                check("txDoneSeen", {7'd0, got}, 8'd1);
                if (got) check("txBusyAtDone", {7'd0, txBusy}, 8'd0);
            end
        end
    end

    initial begin : stim
        bit found;
        rstN    = 1'b0;
        rxEn    = 1'b1;
        txEn    = 1'b1;
        rxDrive = 1'b1;
        loop    = 1'b0;
        txStart = 1'b0;
        inByte  = 8'h00;
        repeat (5) @(negedge clk);
        check("rstTx",     {7'd0, tx},     8'd1);
        check("rstRxBusy", {7'd0, rxBusy}, 8'd0);
        check("rstRxDone", {7'd0, rxDone}, 8'd0);
        check("rstRxErr",  {7'd0, rxErr},  8'd0);
        check("rstTxBusy", {7'd0, txBusy}, 8'd0);
        check("rstTxDone", {7'd0, txDone}, 8'd0);
        check("rstOut",    outByte,        8'h00);
        rstN = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0x55.
        rxExp.push_back(8'h55);
        sendRx(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        check("rx55Err", {7'd0, rxErr}, 8'd0);

        // 20 us glitch on idle line: false start.
        driveBit(1'b0, 240);
        driveBit(1'b1, 900);
        check("glitchBusy", {7'd0, rxBusy}, 8'd0);
        check("glitchErr",  {7'd0, rxErr},  8'd0);
        check("glitchOut",  outByte,        8'h55);

        // Transmit 0xA3; a second request while busy must be ignored.
        pushTxFrame(8'hA3);
        startTx(8'hA3);
        check("txBusyAfterStart", {7'd0, txBusy}, 8'd1);
        repeat (3000) @(negedge clk);
        startTx(8'h5A);
        repeat (9700) @(negedge clk);
        check("txA3BusyLow", {7'd0, txBusy}, 8'd0);
        check("txA3Idle",    {7'd0, tx},     8'd1);

        // Loopback: 0x00 then 0xFF, second accepted in the txDone cycle.
        loop = 1'b1;
        rxExp.push_back(8'h00);
        rxExp.push_back(8'hFF);
        pushTxFrame(8'h00);
        pushTxFrame(8'hFF);
        startTx(8'h00);
        found = 1'b0;
        for (int w = 0; w < 14000 && !found; w++) begin
            @(negedge clk);
            if (txDone === 1'b1) found = 1'b1;
        end
        check("loopDone00", {7'd0, found}, 8'd1);
        startTx(8'hFF);
        found = 1'b0;
        for (int w = 0; w < 14000 && !found; w++) begin
            @(negedge clk);
            if (txDone === 1'b1) found = 1'b1;
        end
        check("loopDoneFF", {7'd0, found}, 8'd1);
        repeat (100) @(negedge clk);
        check("loopOut", outByte, 8'hFF);
        loop = 1'b0;
        repeat (20) @(negedge clk);

        // Framing error: stop bit low around its centre.
        sendRx(8'b01010101, 1'b1);
        repeat (200) @(negedge clk);
        check("badStopErr",  {7'd0, rxErr},  8'd1);
        check("badStopBusy", {7'd0, rxBusy}, 8'd0);
        check("badStopOut",  outByte,        8'hFF);

        // Disabling the receiver clears the error flag.
        rxEn = 1'b0;
        repeat (3) @(negedge clk);
        check("rxEnClearsErr", {7'd0, rxErr}, 8'd0);
        rxEn = 1'b1;
        repeat (10) @(negedge clk);

        check("rxQueueEmpty", 8'(rxExp.size()), 8'd0);
        check("txQueueEmpty", 8'(txExp.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
